// File: rtl/weight_pingpong_buf_pkg.sv
// Shared constants and types for the weight ping-pong buffer.
// Captures the waddr field layout and bank geometry.
package weight_pingpong_buf_pkg;
  localparam int DW         = 32;
  localparam int TAP_WORDS  = 8;
  localparam int N_TAP3     = 9;
  localparam int BANK_WORDS = N_TAP3 * TAP_WORDS + TAP_WORDS;
  localparam int W3_WORDS   = 72;
  localparam int W1_BASE    = 72;
  localparam int TAP_BITS   = DW * TAP_WORDS;

  localparam int SEL_BIT    = 31;
  localparam int TAG_MSB    = 30;
  localparam int TAG_LSB    = 23;
  localparam int OFS_MSB    = 22;

  typedef logic bank_t;
endpackage

// File: rtl/wt_bank.sv
// One 80x32 weight bank: single write port, registered
// 8-word tap read.
module wt_bank
  import weight_pingpong_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [6:0]          waddr,
  input  logic [DW-1:0]       wdata,
  input  logic                re,
  input  logic [3:0]          tap,
  output logic [TAP_BITS-1:0] rdata
);

  logic [DW-1:0] mem [BANK_WORDS];
  logic [6:0]    base;

  assign base = {tap, 3'b000};

  // storage is not reset; the owner's full flag gates visibility
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      for (int k = 0; k < TAP_WORDS; k++)
        rdata[k*DW +: DW] <= mem[base + 7'(k)];
    end
  end

endmodule

// File: rtl/weight_pingpong_buf.sv
// Two-bank weight buffer between the weight bus unit and the
// MAC array: one bank fills while the other is consumed.
module weight_pingpong_buf
  import weight_pingpong_buf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         weight_waddr,
  input  logic [DW-1:0]       weight_wdata,
  input  logic                weight_wen,
  output logic                load_allow,
  output logic                bank_filled,
  output logic                mac_wt_vld,
  output logic [7:0]          mac_out_ch,
  input  logic                mac_rd_en,
  input  logic [3:0]          mac_rd_tap,
  output logic [TAP_BITS-1:0] mac_rd_data,
  output logic                mac_rd_dvld,
  input  logic                mac_release,
  output logic                buf_err
);

  bank_t               wr_bank;
  bank_t               rd_bank;
  bank_t               rd_sel;
  logic [1:0]          full;
  logic [6:0]          fill_cnt;
  logic [7:0]          tag [2];
  logic [TAP_BITS-1:0] rdata [2];

  logic [20:0] word;
  logic        sel_1x1;
  logic [7:0]  tag_in;
  logic [6:0]  loc;
  logic        legal;
  logic        tag_ok;
  logic        accept;
  logic        done;
  logic        rel_ok;
  logic        rd_ok;
  logic        tap_bad;
  logic        unused_lsb;

  assign word       = weight_waddr[OFS_MSB:2];
  assign sel_1x1    = weight_waddr[SEL_BIT];
  assign tag_in     = weight_waddr[TAG_MSB:TAG_LSB];
  assign unused_lsb = ^weight_waddr[1:0];

  assign legal  = sel_1x1 ? (word < 21'(TAP_WORDS))
                          : (word < 21'(W3_WORDS));
  assign loc    = sel_1x1 ? 7'(W1_BASE) + word[6:0]
                          : word[6:0];
  // the first word of a bank defines its tag
  assign tag_ok = (fill_cnt == '0) || (tag_in == tag[wr_bank]);
  assign accept = weight_wen && !full[wr_bank] && legal && tag_ok;
  assign done   = accept && (fill_cnt == 7'(BANK_WORDS - 1));

  assign tap_bad = mac_rd_tap > 4'(N_TAP3);
  assign rd_ok   = mac_rd_en && full[rd_bank] && !tap_bad;
  assign rel_ok  = mac_release && full[rd_bank];

  assign load_allow  = !full[wr_bank];
  assign mac_wt_vld  = full[rd_bank];
  assign mac_out_ch  = tag[rd_bank];
  assign mac_rd_data = rdata[rd_sel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    wt_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && (wr_bank == bank_t'(b))),
      .waddr (loc),
      .wdata (weight_wdata),
      .re    (rd_ok && (rd_bank == bank_t'(b))),
      .tap   (mac_rd_tap),
      .rdata (rdata[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      rd_sel      <= 1'b0;
      full        <= '0;
      fill_cnt    <= '0;
      tag[0]      <= '0;
      tag[1]      <= '0;
      bank_filled <= 1'b0;
      mac_rd_dvld <= 1'b0;
      buf_err     <= 1'b0;
    end else begin
      bank_filled <= done;
      mac_rd_dvld <= rd_ok;
      if (rd_ok) rd_sel <= rd_bank;
      if ((weight_wen && !accept) || (mac_rd_en && tap_bad))
        buf_err <= 1'b1;
      if (accept && (fill_cnt == '0))
        tag[wr_bank] <= tag_in;
      if (done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= !wr_bank;
        fill_cnt      <= '0;
      end else if (accept) begin
        fill_cnt <= fill_cnt + 7'd1;
      end
      // a bank cannot be filling and full at once, so no clash
      if (rel_ok) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_weight_pingpong_buf.sv
// Directed bench for weight_pingpong_buf: vector table for
// single-cycle corner cases plus fill/read/release sequences.
module tb_weight_pingpong_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  weight_waddr;
  logic [31:0]  weight_wdata;
  logic         weight_wen;
  logic         load_allow;
  logic         bank_filled;
  logic         mac_wt_vld;
  logic [7:0]   mac_out_ch;
  logic         mac_rd_en;
  logic [3:0]   mac_rd_tap;
  logic [255:0] mac_rd_data;
  logic         mac_rd_dvld;
  logic         mac_release;
  logic         buf_err;

  int n_cmp = 0;
  int n_bad = 0;

  weight_pingpong_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .weight_waddr (weight_waddr),
    .weight_wdata (weight_wdata),
    .weight_wen   (weight_wen),
    .load_allow   (load_allow),
    .bank_filled  (bank_filled),
    .mac_wt_vld   (mac_wt_vld),
    .mac_out_ch   (mac_out_ch),
    .mac_rd_en    (mac_rd_en),
    .mac_rd_tap   (mac_rd_tap),
    .mac_rd_data  (mac_rd_data),
    .mac_rd_dvld  (mac_rd_dvld),
    .mac_release  (mac_release),
    .buf_err      (buf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          wen;
    logic [31:0] addr;
    bit          rd;
    logic [3:0]  tap;
    bit          rel;
    bit          e_la;
    bit          e_vld;
    bit          e_dvld;
    bit          e_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wa(input logic s,
                                     input logic [7:0] tg,
                                     input int w);
    return {s, tg, 23'(w * 4)};
  endfunction

  function automatic logic [255:0] tap_exp(input logic [31:0] base,
                                           input int t);
    logic [255:0] r;
    for (int k = 0; k < 8; k++)
      r[k*32 +: 32] = base + 32'(t * 8 + k);
    return r;
  endfunction

  task automatic idle();
    weight_wen  = 1'b0;
    mac_rd_en   = 1'b0;
    mac_release = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    weight_waddr = a;
    weight_wdata = d;
    weight_wen   = 1'b1;
    cycle();
    weight_wen   = 1'b0;
  endtask

  task automatic rd(input int t, input logic [31:0] base);
    mac_rd_en  = 1'b1;
    mac_rd_tap = 4'(t);
    cycle();
    mac_rd_en  = 1'b0;
    chk($sformatf("rd_dvld_t%0d", t), mac_rd_dvld, 1);
    chk($sformatf("rd_data_t%0d", t), mac_rd_data, tap_exp(base, t));
  endtask

  task automatic fill(input logic [7:0] tg, input logic [31:0] base,
                      input int bad_at, input bit rel_last);
    int early;
    early = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == bad_at) wr(wa(1'b0, tg ^ 8'h80, 0), 32'hDEAD_BEEF);
      weight_waddr = (i >= 72) ? wa(1'b1, tg, i - 72)
                               : wa(1'b0, tg, i);
      weight_wdata = base + 32'(i);
      weight_wen   = 1'b1;
      mac_release  = rel_last && (i == 79);
      cycle();
      weight_wen   = 1'b0;
      mac_release  = 1'b0;
      if (i < 79 && bank_filled) early++;
    end
    chk("fill_early_pulse", early, 0);
    chk("fill_pulse", bank_filled, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, wa(0, 8'h03, 72), 0, 4'd0, 0, 1, 0, 0, 1};
    tbl[1] = '{1, 1, wa(1, 8'h03, 8),  0, 4'd0, 0, 1, 0, 0, 1};
    tbl[2] = '{1, 1, wa(1, 8'h03, 7),  0, 4'd0, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 1, wa(0, 8'h04, 0),  0, 4'd0, 0, 1, 0, 0, 1};
    tbl[4] = '{1, 0, 32'h0,            1, 4'd9, 0, 1, 0, 0, 0};
    tbl[5] = '{1, 0, 32'h0,            1, 4'd10, 0, 1, 0, 0, 1};
    tbl[6] = '{1, 0, 32'h0,            0, 4'd0, 1, 1, 0, 0, 0};
    tbl[7] = '{1, 1, wa(0, 8'hFF, 71), 0, 4'd0, 0, 1, 0, 0, 0};
    tbl[8] = '{0, 1, wa(0, 8'hFF, 71) | 32'h1,
               0, 4'd0, 0, 1, 0, 0, 0};

    weight_waddr = '0;
    weight_wdata = '0;
    mac_rd_tap   = '0;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_load_allow", load_allow, 1);
    chk("rst_bank_filled", bank_filled, 0);
    chk("rst_wt_vld", mac_wt_vld, 0);
    chk("rst_out_ch", mac_out_ch, 0);
    chk("rst_rd_data", mac_rd_data, 0);
    chk("rst_rd_dvld", mac_rd_dvld, 0);
    chk("rst_buf_err", buf_err, 0);
    rst_n = 1'b1;

    // single bank fill, tap 9 read, then taps 0..8 back-to-back
    fill(8'h05, 32'h0, -1, 1'b0);
    cycle();
    chk("fill_pulse_end", bank_filled, 0);
    chk("b0_vld", mac_wt_vld, 1);
    chk("b0_ch", mac_out_ch, 8'h05);
    chk("b0_la", load_allow, 1);
    chk("b0_err", buf_err, 0);
    rd(9, 32'h0);
    cycle();
    chk("rd_dvld_drop", mac_rd_dvld, 0);
    mac_rd_en = 1'b1;
    for (int t = 0; t < 9; t++) begin
      mac_rd_tap = 4'(t);
      cycle();
      chk($sformatf("b2b_dvld_t%0d", t), mac_rd_dvld, 1);
      chk($sformatf("b2b_data_t%0d", t), mac_rd_data,
          tap_exp(32'h0, t));
    end
    mac_rd_en = 1'b0;
    cycle();
    chk("b2b_dvld_end", mac_rd_dvld, 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      weight_waddr = tbl[i].addr;
      weight_wdata = 32'h5555_0000 + 32'(i);
      weight_wen   = tbl[i].wen;
      mac_rd_en    = tbl[i].rd;
      mac_rd_tap   = tbl[i].tap;
      mac_release  = tbl[i].rel;
      cycle();
      idle();
      chk($sformatf("vec%0d_la", i), load_allow, tbl[i].e_la);
      chk($sformatf("vec%0d_vld", i), mac_wt_vld, tbl[i].e_vld);
      chk($sformatf("vec%0d_dvld", i), mac_rd_dvld, tbl[i].e_dvld);
      chk($sformatf("vec%0d_err", i), buf_err, tbl[i].e_err);
    end

    // both banks full, overflow write, release with same-cycle read
    do_reset();
    fill(8'h01, 32'h100, -1, 1'b0);
    fill(8'h02, 32'h200, -1, 1'b0);
    chk("both_la", load_allow, 0);
    chk("both_err", buf_err, 0);
    chk("both_ch", mac_out_ch, 8'h01);
    wr(wa(1'b0, 8'h03, 0), 32'h0000_0BAD);
    chk("ovf_err", buf_err, 1);
    chk("ovf_la", load_allow, 0);
    rd(0, 32'h100);
    mac_release = 1'b1;
    mac_rd_en   = 1'b1;
    mac_rd_tap  = 4'd3;
    cycle();
    idle();
    chk("relrd_dvld", mac_rd_dvld, 1);
    chk("relrd_data", mac_rd_data, tap_exp(32'h100, 3));
    chk("rel_ch", mac_out_ch, 8'h02);
    chk("rel_la", load_allow, 1);
    chk("rel_vld", mac_wt_vld, 1);
    rd(0, 32'h200);
    rd(9, 32'h200);

    // fill completion on bank 0 with release of bank 1 together
    fill(8'h07, 32'h700, -1, 1'b1);
    chk("sim_ch", mac_out_ch, 8'h07);
    chk("sim_vld", mac_wt_vld, 1);
    chk("sim_la", load_allow, 1);
    rd(9, 32'h700);
    mac_release = 1'b1;
    cycle();
    idle();
    chk("sim_rel_vld", mac_wt_vld, 0);
    chk("sim_rel_la", load_allow, 1);

    // dropped writes must not count toward completion
    do_reset();
    wr(wa(1'b0, 8'h01, 72), 32'h0000_0BAD);
    chk("ill_err", buf_err, 1);
    fill(8'h01, 32'h100, 40, 1'b0);
    chk("tagchg_ch", mac_out_ch, 8'h01);
    rd(0, 32'h100);

    // asynchronous reset in the middle of a fill
    do_reset();
    fill(8'h05, 32'h500, -1, 1'b0);
    rd(2, 32'h500);
    wr(wa(1'b1, 8'h05, 9), 32'h0);
    chk("pre_rst_err", buf_err, 1);
    for (int i = 0; i < 40; i++) wr(wa(1'b0, 8'h09, i), 32'(i));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_la", load_allow, 1);
    chk("arst_vld", mac_wt_vld, 0);
    chk("arst_ch", mac_out_ch, 0);
    chk("arst_data", mac_rd_data, 0);
    chk("arst_dvld", mac_rd_dvld, 0);
    chk("arst_err", buf_err, 0);
    chk("arst_filled", bank_filled, 0);
    #2;
    rst_n = 1'b1;
    fill(8'h0A, 32'hA00, -1, 1'b0);
    chk("post_rst_vld", mac_wt_vld, 1);
    chk("post_rst_ch", mac_out_ch, 8'h0A);
    rd(4, 32'hA00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
